// File: rtl/fe25519_pkg.sv
// Shared definitions for the Curve25519 field-element datapath.
// Used by the limb-serial modular adder and subtractor.
//   LIMB_W    : limb width in bits (64)
//   NUM_LIMBS : limbs per field element (4)
//   FE_W      : field-element width in bits (256)
//   P25519    : field prime p = 2^255 - 19
//   fe_state_t: control states of the limb-serial units
package fe25519_pkg;

  localparam int unsigned LIMB_W    = 64;
  localparam int unsigned NUM_LIMBS = 4;
  localparam int unsigned FE_W      = LIMB_W * NUM_LIMBS;

  localparam logic [FE_W-1:0] P25519 =
    256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fe_state_t;

endpackage

// File: rtl/limb_addsub64.sv
// Combinational single-limb adder/subtractor.
//   i_x, i_y : limb operands
//   i_cin    : carry-in (add) or borrow-in (subtract)
//   i_sub    : 1 -> o_s = x - y - cin, o_cout = borrow out
//              0 -> o_s = x + y + cin, o_cout = carry out
module limb_addsub64 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_cin,
  input  logic         i_sub,
  output logic [W-1:0] o_s,
  output logic         o_cout
);

  logic [W:0] w_ext;

  // One extra bit holds the carry; for subtraction it becomes 1 exactly
  // when the difference went negative, i.e. it is the borrow.
  always_comb begin
    w_ext = '0;
    if (i_sub) begin
      w_ext = {1'b0, i_x} - {1'b0, i_y} - {{W{1'b0}}, i_cin};
    end else begin
      w_ext = {1'b0, i_x} + {1'b0, i_y} + {{W{1'b0}}, i_cin};
    end
  end

  assign o_s    = w_ext[W-1:0];
  assign o_cout = w_ext[W];

endmodule

// File: rtl/mod_sub_256_serial.sv
// Limb-serial modular subtractor: result = (a - b) mod p, p = 2^255 - 19.
// Processes one 64-bit limb per cycle, LSB first. Each cycle produces the
// raw difference limb d and the corrected limb e = d + p; the final borrow
// of d selects which 256-bit word is returned.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle request, honoured only in IDLE
//   a, b       : minuend / subtrahend, captured on an accepted start
//   busy       : high from the cycle after accept through the done cycle
//   done       : one-cycle pulse, result valid in that cycle
//   result     : (a - b) mod p, held until the next done
//   borrow_out : final borrow of a - b (1 when a < b)
// Start-to-done latency is 5 cycles; one operation every 6 cycles.
module mod_sub_256_serial #(
  parameter int unsigned LIMB_W    = 64,
  parameter int unsigned NUM_LIMBS = 4,
  parameter logic [LIMB_W*NUM_LIMBS-1:0] PRIME = fe25519_pkg::P25519
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LIMB_W*NUM_LIMBS-1:0]   a,
  input  logic [LIMB_W*NUM_LIMBS-1:0]   b,
  output logic                          busy,
  output logic                          done,
  output logic [LIMB_W*NUM_LIMBS-1:0]   result,
  output logic                          borrow_out
);

  import fe25519_pkg::*;

  localparam int unsigned W     = LIMB_W * NUM_LIMBS;
  localparam int unsigned CNT_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);

  fe_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_p;
  logic [W-1:0]      r_d_sr;
  logic [W-1:0]      r_e_sr;
  logic              r_borrow;
  logic              r_carry;
  logic [W-1:0]      r_result;
  logic              r_done;
  logic              r_busy;
  logic              r_borrow_out;

  logic [LIMB_W-1:0] w_d;
  logic              w_borrow;
  logic [LIMB_W-1:0] w_e;
  logic              w_carry;

  // d_i = a_i - b_i - borrow
  limb_addsub64 #(.W(LIMB_W)) u_sub (
    .i_x    (r_a[LIMB_W-1:0]),
    .i_y    (r_b[LIMB_W-1:0]),
    .i_cin  (r_borrow),
    .i_sub  (1'b1),
    .o_s    (w_d),
    .o_cout (w_borrow)
  );

  // e_i = d_i + p_i + carry; the carry out of the top limb is dropped,
  // so e is (d + p) mod 2^256.
  limb_addsub64 #(.W(LIMB_W)) u_add (
    .i_x    (w_d),
    .i_y    (r_p[LIMB_W-1:0]),
    .i_cin  (r_carry),
    .i_sub  (1'b0),
    .o_s    (w_e),
    .o_cout (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_p          <= '0;
      r_d_sr       <= '0;
      r_e_sr       <= '0;
      r_borrow     <= 1'b0;
      r_carry      <= 1'b0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_borrow_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // busy drops here, one cycle after done, unless a new job starts
          r_busy <= start;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_p      <= PRIME;
            r_borrow <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          // Limbs enter at the top and move down, so after the last limb
          // limb 0 sits in the low 64 bits.
          r_d_sr   <= {w_d, r_d_sr[W-1:LIMB_W]};
          r_e_sr   <= {w_e, r_e_sr[W-1:LIMB_W]};
          r_a      <= {{LIMB_W{1'b0}}, r_a[W-1:LIMB_W]};
          r_b      <= {{LIMB_W{1'b0}}, r_b[W-1:LIMB_W]};
          r_p      <= {{LIMB_W{1'b0}}, r_p[W-1:LIMB_W]};
          r_borrow <= w_borrow;
          r_carry  <= w_carry;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_LIMB) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_result     <= r_borrow ? r_e_sr : r_d_sr;
          r_borrow_out <= r_borrow;
          r_done       <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign borrow_out = r_borrow_out;

endmodule
